// File: rtl/ft245_bridge_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ft245_bridge_pkg
// Purpose  : Shared state encoding, command nibbles and parameter defaults
//            for the FT245 bridge and the host register decoder.
// Revision : 1.0 - initial release
// ============================================================================
package ft245_bridge_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RD_ASSERT = 3'd1,
        RD_DONE   = 3'd2,
        WR_SETUP  = 3'd3,
        WR_HOLD   = 3'd4,
        RECOVER   = 3'd5
    } state_t;

    // Command nibbles understood by the register decoder.
    localparam logic [3:0] READ_CMD  = 4'hA;
    localparam logic [3:0] WRITE_CMD = 4'h5;

    localparam int c_RD_CYC_DEF    = 3;
    localparam int c_WR_CYC_DEF    = 3;
    localparam int c_RECOV_CYC_DEF = 4;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ft245_bridge_sync2.sv
`default_nettype none
// ============================================================================
// Module   : ft245_bridge_sync2
// Purpose  : Two-flop synchroniser for the active-low FT245 status flags;
//            resets to 1 (flag inactive).
// Revision : 1.0 - initial release
// ============================================================================
module ft245_bridge_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule
`default_nettype wire

// File: rtl/ft245_bridge.sv
`default_nettype none
// ============================================================================
// Module   : ft245_bridge
// Purpose  : Paced FT245 USB-FIFO read/write engine feeding the host
//            register decoder with one-cycle byte strobes.
// Revision : 1.0 - initial release
// ============================================================================
module ft245_bridge
    import ft245_bridge_pkg::*;
#(
    parameter int RD_CYC    = c_RD_CYC_DEF,
    parameter int WR_CYC    = c_WR_CYC_DEF,
    parameter int RECOV_CYC = c_RECOV_CYC_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       _usb_rxf,
    input  logic       _usb_txe,
    input  logic [7:0] usb_din,
    output logic [7:0] usb_dout,
    output logic       usb_doe,
    output logic       _usb_rd,
    output logic       usb_wr,
    output logic [7:0] ft_byte_out,
    output logic       _ft_rxf,
    output logic       _ft_wr,
    input  logic [7:0] ft_byte_in,
    input  logic       _serial_rd,
    input  logic       _serial_wr,
    output logic       _ft_rd,
    output logic       bridge_sump
);

    localparam int c_CNT_MAX = max3(RD_CYC, WR_CYC, RECOV_CYC);
    localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);

    localparam logic [c_CNT_W-1:0] c_RD_LOAD    = c_CNT_W'(RD_CYC - 1);
    localparam logic [c_CNT_W-1:0] c_WR_LOAD    = c_CNT_W'(WR_CYC - 1);
    localparam logic [c_CNT_W-1:0] c_RECOV_LOAD = c_CNT_W'(RECOV_CYC - 1);

    state_t             r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_usb_rd_n;
    logic               r_usb_wr;
    logic               r_usb_doe;
    logic [7:0]         r_usb_dout;
    logic [7:0]         r_byte_out;
    logic               r_rx_stb_n;
    logic               r_tx_stb_n;

    logic w_rxf_s;
    logic w_txe_s;
    logic w_bad_state;

    ft245_bridge_sync2 u_sync_rxf (
        .clk (clk),
        .rst (reset),
        .i_d (_usb_rxf),
        .o_q (w_rxf_s)
    );

    ft245_bridge_sync2 u_sync_txe (
        .clk (clk),
        .rst (reset),
        .i_d (_usb_txe),
        .o_q (w_txe_s)
    );

    // Every output is set on the edge that enters the state it belongs to,
    // so pin timing is exactly one register away from the FSM decision.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_usb_rd_n <= 1'b1;
            r_usb_wr   <= 1'b0;
            r_usb_doe  <= 1'b0;
            r_usb_dout <= 8'h00;
            r_byte_out <= 8'h00;
            r_rx_stb_n <= 1'b1;
            r_tx_stb_n <= 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    if (!_serial_rd && !w_txe_s) begin
                        r_state    <= WR_SETUP;
                        r_cnt      <= c_WR_LOAD;
                        r_usb_dout <= ft_byte_in;
                        r_usb_doe  <= 1'b1;
                        r_usb_wr   <= 1'b1;
                    end else if (!w_rxf_s) begin
                        r_state    <= RD_ASSERT;
                        r_cnt      <= c_RD_LOAD;
                        r_usb_rd_n <= 1'b0;
                    end
                end
                RD_ASSERT: begin
                    if (r_cnt == '0) begin
                        r_state    <= RD_DONE;
                        r_usb_rd_n <= 1'b1;
                        r_byte_out <= usb_din;
                        r_rx_stb_n <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                RD_DONE: begin
                    r_state    <= RECOVER;
                    r_cnt      <= c_RECOV_LOAD;
                    r_rx_stb_n <= 1'b1;
                end
                WR_SETUP: begin
                    if (r_cnt == '0) begin
                        r_state    <= WR_HOLD;
                        r_usb_wr   <= 1'b0;
                        r_tx_stb_n <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                WR_HOLD: begin
                    // Bus stays driven through the WR falling edge, released here.
                    r_state    <= RECOVER;
                    r_cnt      <= c_RECOV_LOAD;
                    r_tx_stb_n <= 1'b1;
                    r_usb_doe  <= 1'b0;
                end
                RECOVER: begin
                    if (r_cnt == '0) begin
                        r_state <= IDLE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: begin
                    r_state    <= IDLE;
                    r_cnt      <= '0;
                    r_usb_rd_n <= 1'b1;
                    r_usb_wr   <= 1'b0;
                    r_usb_doe  <= 1'b0;
                    r_rx_stb_n <= 1'b1;
                    r_tx_stb_n <= 1'b1;
                end
            endcase
        end
    end

    // Encodings 6 and 7 are unreachable; _serial_wr is informational only.
    assign w_bad_state = r_state[2] & r_state[1];
    assign bridge_sump = w_bad_state | (w_bad_state & ~_serial_wr);

    assign usb_dout    = r_usb_dout;
    assign usb_doe     = r_usb_doe;
    assign _usb_rd     = r_usb_rd_n;
    assign usb_wr      = r_usb_wr;
    assign ft_byte_out = r_byte_out;
    assign _ft_rxf     = r_rx_stb_n;
    assign _ft_wr      = r_rx_stb_n;
    assign _ft_rd      = r_tx_stb_n;

endmodule
`default_nettype wire
